// File: rtl/cc_frame_sequencer_if.sv
// Stream bundle for the CC frame sequencer: 4-bit nibble input and 9-bit result output.
// A beat moves on a rising edge when valid && ready; a raised valid holds its data until that edge.
interface cc_frame_sequencer_if;
    logic       in_valid;
    logic [3:0] in_data;
    logic       in_ready;
    logic       out_valid;
    logic [8:0] out_data;
    logic       out_ready;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/cc_frame_sequencer.sv
// Collects four operand nibbles and an opt nibble, holds them on the CC inputs for one
// evaluation cycle, then offers the registered CC result on a backpressured output.
module cc_frame_sequencer #(
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    cc_frame_sequencer_if.slave  bus,
    output logic [3:0]           cc_in_n0,
    output logic [3:0]           cc_in_n1,
    output logic [3:0]           cc_in_n2,
    output logic [3:0]           cc_in_n3,
    output logic [3:0]           cc_opt,
    input  logic [8:0]           cc_out_n,
    output logic                 err_timeout,
    output logic [CNT_W-1:0]     frame_cnt,
    output logic [1:0]           dbg_state_o
);

    localparam int GAP_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {
        S_COLLECT = 2'd0,
        S_EVAL    = 2'd1,
        S_HOLD    = 2'd2
    } state_e;

    state_e           state_q;
    logic [2:0]       idx_q;
    logic [GAP_W-1:0] gap_q;
    logic [GAP_W-1:0] gap_d;
    logic             in_ready_q;
    logic             out_valid_q;
    logic [8:0]       out_data_q;
    logic [3:0]       n0_q, n1_q, n2_q, n3_q, opt_q;
    logic             err_q;
    logic [CNT_W-1:0] cnt_q;

    logic in_xfer;
    logic out_xfer;
    logic gap_inc;
    logic tmo_fire;

    always_comb begin
        in_xfer  = (state_q == S_COLLECT) && bus.in_valid && in_ready_q;
        out_xfer = (state_q == S_HOLD) && out_valid_q && bus.out_ready;
        gap_inc  = (TIMEOUT > 0) && (state_q == S_COLLECT) && (idx_q != 3'd0) && !bus.in_valid;
        gap_d    = gap_q + 1'b1;
        // The edge that would bring the gap count to TIMEOUT discards the partial frame.
        tmo_fire = gap_inc && (gap_d == GAP_W'(TIMEOUT));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_COLLECT;
            idx_q       <= 3'd0;
            gap_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_data_q  <= 9'd0;
            n0_q        <= 4'd0;
            n1_q        <= 4'd0;
            n2_q        <= 4'd0;
            n3_q        <= 4'd0;
            opt_q       <= 4'd0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                S_COLLECT: begin
                    if (in_xfer) begin
                        gap_q <= '0;
                        case (idx_q)
                            3'd0:    n0_q  <= bus.in_data;
                            3'd1:    n1_q  <= bus.in_data;
                            3'd2:    n2_q  <= bus.in_data;
                            3'd3:    n3_q  <= bus.in_data;
                            default: opt_q <= bus.in_data;
                        endcase
                        if (idx_q == 3'd4) begin
                            idx_q      <= 3'd0;
                            in_ready_q <= 1'b0;
                            state_q    <= S_EVAL;
                        end else begin
                            idx_q <= idx_q + 3'd1;
                        end
                    end else if (tmo_fire) begin
                        // Slots already written stay as they are; only the index rewinds.
                        idx_q <= 3'd0;
                        gap_q <= '0;
                        err_q <= 1'b1;
                    end else if (gap_inc) begin
                        gap_q <= gap_d;
                    end else begin
                        gap_q <= '0;
                    end
                end
                S_EVAL: begin
                    out_data_q  <= cc_out_n;
                    out_valid_q <= 1'b1;
                    state_q     <= S_HOLD;
                end
                S_HOLD: begin
                    if (out_xfer) begin
                        out_valid_q <= 1'b0;
                        cnt_q       <= cnt_q + 1'b1;
                        in_ready_q  <= 1'b1;
                        state_q     <= S_COLLECT;
                    end
                end
                default: begin
                    state_q    <= S_COLLECT;
                    idx_q      <= 3'd0;
                    gap_q      <= '0;
                    in_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign cc_in_n0      = n0_q;
    assign cc_in_n1      = n1_q;
    assign cc_in_n2      = n2_q;
    assign cc_in_n3      = n3_q;
    assign cc_opt        = opt_q;
    assign err_timeout   = err_q;
    assign frame_cnt     = cnt_q;
    assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_cc_frame_sequencer.sv
// Randomized bench for cc_frame_sequencer: frame-level driver, CC stub, result scoreboard.
module tb_cc_frame_sequencer;

    localparam int TIMEOUT = 15;
    localparam int CNT_W   = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic [3:0]       cc_in_n0, cc_in_n1, cc_in_n2, cc_in_n3, cc_opt;
    logic [8:0]       cc_out_n;
    logic             err_timeout;
    logic [CNT_W-1:0] frame_cnt;
    logic [1:0]       dbg_state;

    cc_frame_sequencer_if bus ();

    cc_frame_sequencer #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus.slave),
        .cc_in_n0    (cc_in_n0),
        .cc_in_n1    (cc_in_n1),
        .cc_in_n2    (cc_in_n2),
        .cc_in_n3    (cc_in_n3),
        .cc_opt      (cc_opt),
        .cc_out_n    (cc_out_n),
        .err_timeout (err_timeout),
        .frame_cnt   (frame_cnt),
        .dbg_state_o (dbg_state)
    );

    always #5 clk = ~clk;

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [8:0] exp_q[$];
    int         exp_cnt = 0;
    int         err_seen = 0;
    int         exp_err = 0;
    bit         stub_fix = 1'b0;
    logic [8:0] stub_val = 9'd0;
    bit         ready_rand = 1'b0;
    logic       ready_force = 1'b1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // CC stub: a fresh value every cycle, so only the EVAL-cycle value can match.
    always @(negedge clk) begin
        if (stub_fix) cc_out_n = stub_val;
        else          cc_out_n = 9'($urandom);
    end

    always @(negedge clk) begin
        if (ready_rand) bus.out_ready = 1'($urandom_range(0, 1));
        else            bus.out_ready = ready_force;
    end

    // Result monitor: samples 1 time unit before each rising edge.
    initial begin : monitor
        logic       prev_hold;
        logic [8:0] prev_data;
        prev_hold = 1'b0;
        prev_data = 9'd0;
        forever begin
            @(negedge clk);
            #4;
            if (!rst_n) begin
                exp_q.delete();
                exp_cnt   = 0;
                prev_hold = 1'b0;
            end else begin
                if (err_timeout) err_seen++;
                if (prev_hold) begin
                    check("hold_valid", bus.out_valid, 1);
                    check("hold_data", bus.out_data, prev_data);
                end
                if (bus.out_valid && bus.out_ready) begin
                    if (exp_q.size() == 0) begin
                        check("spurious_result", bus.out_valid, 0);
                    end else begin
                        check("out_data", bus.out_data, exp_q.pop_front());
                        check("frame_cnt", frame_cnt, exp_cnt[CNT_W-1:0]);
                        exp_cnt++;
                    end
                end
                prev_hold = bus.out_valid && !bus.out_ready;
                prev_data = bus.out_data;
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish, n_tests=%0d", n_tests);
        $fatal(1, "watchdog");
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
            bus.in_data  = 4'($urandom);
        end
    endtask

    task automatic send_nib(input logic [3:0] d);
        int w;
        w = 0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        #4;
        while (!bus.in_ready && w < 50) begin
            @(negedge clk);
            #4;
            w++;
        end
        if (w >= 50) check("in_ready_wait", bus.in_ready, 1);
        @(posedge clk);
    endtask

    // fr packs {opt, n3, n2, n1, n0}; nibbles below 'start' were already sent.
    task automatic send_frame(input logic [19:0] fr, input int start, input int max_gap, input bit tight);
        for (int i = start; i < 5; i++) begin
            if (max_gap > 0) idle($urandom_range(0, max_gap));
            send_nib(fr[4*i +: 4]);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        #4;
        check("eval_in_ready", bus.in_ready, 0);
        check("eval_out_valid", bus.out_valid, 0);
        check("eval_slots", {cc_opt, cc_in_n3, cc_in_n2, cc_in_n1, cc_in_n0}, fr);
        exp_q.push_back(cc_out_n);
        if (tight) begin
            @(negedge clk);
            #4;
            check("hold_in_ready", bus.in_ready, 0);
            check("hold_out_valid", bus.out_valid, 1);
            @(negedge clk);
            #4;
            check("after_out_valid", bus.out_valid, 0);
            check("after_in_ready", bus.in_ready, 1);
        end
    endtask

    task automatic wait_drain();
        int w;
        w = 0;
        while ((exp_q.size() != 0 || bus.out_valid) && w < 200) begin
            @(negedge clk);
            #4;
            w++;
        end
        if (w >= 200) check("drain", exp_q.size(), 0);
        @(negedge clk);
        #4;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_out_data", bus.out_data, 0);
        check("rst_slots", {cc_opt, cc_in_n3, cc_in_n2, cc_in_n1, cc_in_n0}, 0);
        check("rst_err", err_timeout, 0);
        check("rst_frame_cnt", frame_cnt, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin : main
        logic [19:0] fr;
        int          base_cnt;
        bus.in_valid = 1'b0;
        bus.in_data  = 4'd0;
        ready_force  = 1'b1;

        do_reset();

        // Directed frame 3, -2, 5, 1, opt 0 with a fixed CC result of -14.
        stub_fix = 1'b1;
        stub_val = 9'h1F2;
        send_frame({4'h0, 4'h1, 4'h5, 4'hE, 4'h3}, 0, 0, 1'b1);
        wait_drain();
        check("t1_frame_cnt", frame_cnt, 1);
        stub_fix = 1'b0;

        // Backpressure in HOLD with stray in_valid pulses.
        ready_force = 1'b0;
        @(negedge clk);
        send_frame({4'h0, 4'h1, 4'h5, 4'hE, 4'h3}, 0, 0, 1'b0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            bus.in_valid = 1'($urandom_range(0, 1));
            bus.in_data  = 4'($urandom);
            #4;
            check("bp_in_ready", bus.in_ready, 0);
            check("bp_out_valid", bus.out_valid, 1);
        end
        bus.in_valid = 1'b0;
        ready_force  = 1'b1;
        wait_drain();
        check("t2_frame_cnt", frame_cnt, 2);

        // Partial frame abandoned after TIMEOUT idle cycles.
        send_nib(4'h7);
        send_nib(4'h9);
        idle(TIMEOUT);
        @(negedge clk);
        bus.in_valid = 1'b0;
        #4;
        check("tmo_pulse", err_timeout, 1);
        exp_err++;
        @(negedge clk);
        #4;
        check("tmo_pulse_end", err_timeout, 0);
        fr = 20'($urandom);
        send_frame(fr, 0, 0, 1'b0);
        wait_drain();
        check("t3_frame_cnt", frame_cnt, 3);

        // One cycle short of the timeout: the frame survives.
        fr = 20'($urandom);
        send_nib(fr[3:0]);
        send_nib(fr[7:4]);
        idle(TIMEOUT - 1);
        send_frame(fr, 2, 0, 1'b0);
        wait_drain();
        check("t4_frame_cnt", frame_cnt, 4);

        // Asynchronous reset while a result is pending.
        ready_force = 1'b0;
        @(negedge clk);
        send_frame(20'($urandom), 0, 0, 1'b0);
        ready_force = 1'b1;
        do_reset();
        fr = 20'($urandom);
        send_frame(fr, 0, 0, 1'b0);
        wait_drain();
        check("t5_frame_cnt", frame_cnt, 1);

        // Random frames, random gaps and random backpressure.
        ready_rand = 1'b1;
        for (int f = 0; f < 40; f++) send_frame(20'($urandom), 0, 3, 1'b0);
        ready_rand = 1'b0;
        wait_drain();
        base_cnt = exp_cnt;
        check("rand_frame_cnt", frame_cnt, 32'(base_cnt % 256));

        // 256 back-to-back frames wrap the counter.
        do_reset();
        for (int f = 0; f < 256; f++) send_frame(20'($urandom), 0, 0, 1'b0);
        wait_drain();
        check("wrap_frame_cnt", frame_cnt, 0);
        check("err_total", err_seen, exp_err);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cc_frame_sequencer.md
Name: cc_frame_sequencer

Overview:
- Sequencer that sits directly around the CC sort/average/arithmetic datapath.
- Collects one CC job over a 4-bit serial ready/valid stream: four signed operand nibbles, then one opt nibble.
- Holds the assembled operands and opt stable on CC's combinational inputs for one evaluation cycle, then registers CC's 9-bit signed result.
- Presents the registered result on a ready/valid output with backpressure.

Parameters:
- TIMEOUT, 15: idle cycles allowed between nibbles of a partially received frame before that frame is discarded. 0 disables the timeout.
- CNT_W, 8: width of the completed-frame counter.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input nibble valid
- in_data  in  4  nibble: operand 0..3 (signed), then opt
- in_ready  out  1  sequencer can accept a nibble
- cc_in_n0  out  4  operand slot 0 to CC
- cc_in_n1  out  4  operand slot 1 to CC
- cc_in_n2  out  4  operand slot 2 to CC
- cc_in_n3  out  4  operand slot 3 to CC
- cc_opt  out  4  opt slot to CC
- cc_out_n  in  9  signed combinational result from CC
- out_valid  out  1  result valid
- out_data  out  9  registered signed CC result
- out_ready  in  1  downstream accepts result
- err_timeout  out  1  one-cycle pulse when a partial frame is discarded
- frame_cnt  out  CNT_W  count of results handed off; wraps modulo 2^CNT_W

Behaviour:
- Clock and reset: single clock clk. rst_n is asynchronous and active-low.
- Reset values: state=COLLECT, idx=0, gap counter=0, in_ready=1, all cc_* outputs=0, out_valid=0, out_data=0, err_timeout=0, frame_cnt=0.
- Reset mid-frame or mid-HOLD aborts immediately. No result is emitted.
- Handshake: a nibble transfers when in_valid && in_ready at a rising edge. A result transfers when out_valid && out_ready at a rising edge.
- State COLLECT:
  - in_ready=1.
  - On transfer, in_data is written to the slot selected by idx: 0→cc_in_n0, 1→cc_in_n1, 2→cc_in_n2, 3→cc_in_n3, 4→cc_opt.
  - idx increments on each transfer.
  - Transfer with idx=4 → idx=0, next state EVAL.
- State EVAL (exactly 1 cycle):
  - in_ready=0.
  - All cc_* outputs are stable, so cc_out_n is valid this cycle.
  - At the closing edge: out_data←cc_out_n, out_valid←1, next state HOLD.
- State HOLD:
  - in_ready=0, out_valid=1, out_data held constant.
  - On a result transfer: out_valid←0, frame_cnt←frame_cnt+1, next state COLLECT.
  - out_ready is ignored outside HOLD.
- Latency: opt nibble accepted at edge k → out_valid high after edge k+1. With out_ready tied high, the result transfers at edge k+2, and the first nibble of the next frame can transfer at edge k+3.
- No overlap: a new frame is never accepted while a result is pending.
- cc_* hold values:
  - cc_* outputs keep their last written values after a transfer; they are not cleared.
  - During COLLECT, slots update one at a time; only the EVAL-cycle value of cc_out_n is ever captured.
- Timeout (TIMEOUT>0):
  - The gap counter increments in COLLECT when idx≠0 and in_valid=0. It clears on any transfer and whenever idx=0.
  - When the gap counter reaches TIMEOUT: idx←0, gap counter←0, err_timeout pulses high for 1 cycle, frame_cnt unchanged. Partially written slots keep their values.
  - If in_valid is high on the same edge the gap counter would reach TIMEOUT, the transfer wins and no timeout occurs.
  - Timeout is never active in EVAL or HOLD.
- Arithmetic: no arithmetic in this block. out_data is a bit-exact copy of cc_out_n, signed 9-bit. frame_cnt wraps from all-ones to 0.

Test Plan:
- Reset, then stream 3, -2 (4'hE), 5, 1, opt 4'h0 with in_valid held high and out_ready=1; CC stub drives cc_out_n=9'h1F2 (-14). Required: in_ready low for 2 cycles; out_valid one cycle, 2 edges after the opt nibble; out_data=9'h1F2; frame_cnt=1.
- Same frame with out_ready=0 for 5 cycles, then 1. Required: out_valid and out_data stable for 6 cycles; in_ready=0 throughout; in_valid pulses during HOLD are ignored; frame_cnt increments once.
- Send 2 nibbles, idle 15 cycles (TIMEOUT=15). Required: err_timeout pulses once; next 5 nibbles form a new complete frame with cc_in_n0 = first new nibble; frame_cnt counts 1 result.
- Send 2 nibbles, idle 14 cycles, then nibble 3. Required: no err_timeout; frame completes normally.
- Assert rst_n=0 asynchronously mid-HOLD. Required: out_valid=0 and all outputs at reset values immediately, without waiting for a clk edge; the next frame starts at slot 0.
- Run 256 back-to-back frames (CNT_W=8). Required: frame_cnt wraps to 0; every out_data equals the stub value driven in that frame's EVAL cycle.
